// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int HEADER_BYTES   = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// Collects bytes LSB first into an instruction word and flags the final byte.
module word_assembler
  import loader_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             byte_valid,
  input  logic [7:0]       byte_in,
  output logic [Width-1:0] word,
  output logic             word_full
);

  logic [1:0] byte_count;

  // Shift register: after four bytes the first byte sits in the low lane.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word       <= {Width{1'b0}};
      byte_count <= 2'd0;
    end else if (byte_valid) begin
      word       <= {byte_in, word[Width-1:8]};
      byte_count <= byte_count + 2'd1;
    end
  end

  assign word_full = (byte_count == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instruction_loader.sv
// Parses a word-count header from a byte stream and writes the following
// little-endian words into instruction memory, holding the core meanwhile.
module instruction_loader
  import loader_pkg::*;
#(
  parameter int Width    = 32,
  parameter int MaxWords = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             wr_en,
  output logic [Width-1:0] wr_address,
  output logic [Width-1:0] wr_data,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);

  localparam int          IDX_W     = $clog2(MaxWords + 1);
  localparam logic [15:0] MAX_COUNT = 16'(MaxWords);

  state_t           state, next_state;
  logic [15:0]      count;
  logic [15:0]      header;
  logic [IDX_W-1:0] index, index_inc;
  logic             xfer, asm_clear, asm_valid, word_full, header_bad;

  assign xfer       = rx_valid && rx_ready;
  assign header     = {rx_data, count[7:0]};
  assign header_bad = (header == 16'd0) || (header > MAX_COUNT);
  assign index_inc  = index + {{(IDX_W-1){1'b0}}, 1'b1};
  assign asm_valid  = xfer && (state == DATA);
  assign asm_clear  = (state == IDLE) && start;

  word_assembler #(.Width(Width)) u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_valid (asm_valid),
    .byte_in    (rx_data),
    .word       (wr_data),
    .word_full  (word_full)
  );

  assign wr_address = Width'({index, 2'b00});

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = LEN0; else next_state = IDLE;
      LEN0:  if (xfer) next_state = LEN1; else next_state = LEN0;
      LEN1: begin
        if (xfer) begin
          if (header_bad) next_state = IDLE;
          else            next_state = DATA;
        end else begin
          next_state = LEN1;
        end
      end
      DATA:  if (xfer && word_full) next_state = WRITE; else next_state = DATA;
      WRITE: if (16'(index_inc) == count) next_state = DONE; else next_state = DATA;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rx_ready <= 1'b0;
      wr_en    <= 1'b0;
      done     <= 1'b0;
      cpu_hold <= 1'b0;
      error    <= 1'b0;
      count    <= 16'd0;
      index    <= {IDX_W{1'b0}};
    end else begin
      state    <= next_state;
      rx_ready <= (next_state == LEN0) || (next_state == LEN1) || (next_state == DATA);
      wr_en    <= (next_state == WRITE);
      done     <= (next_state == DONE);
      cpu_hold <= (next_state != IDLE);
      if (state == LEN0 && xfer) count[7:0]  <= rx_data;
      if (state == LEN1 && xfer) count[15:8] <= rx_data;
      if (asm_clear)             index <= {IDX_W{1'b0}};
      else if (state == WRITE)   index <= index_inc;
      if (asm_clear)                             error <= 1'b0;
      else if (state == LEN1 && xfer && header_bad) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed scoreboard bench for instruction_loader.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        reset, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, wr_en, cpu_hold, done, error;
  logic [31:0] wr_address, wr_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_count = 0;
  int last_wr_cyc = 0;

  logic [63:0] sb_q[$];
  logic [63:0] exp_wr;
  logic [31:0] img [0:2];

  instruction_loader #(.Width(32), .MaxWords(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .wr_en      (wr_en),
    .wr_address (wr_address),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_en) begin
      wr_count++;
      last_wr_cyc = cyc;
      check("write_expected", 32'(sb_q.size() > 0), 32'd1);
      check("hold_during_write", 32'(cpu_hold), 32'd1);
      if (sb_q.size() > 0) begin
        exp_wr = sb_q.pop_front();
        check("wr_address", wr_address, exp_wr[63:32]);
        check("wr_data", wr_data, exp_wr[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      tick();
      n++;
    end
    check("rx_ready_wait", 32'(rx_ready), 32'd1);
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_header(input logic [15:0] c, input int gap);
    send_byte(c[7:0], gap);
    send_byte(c[15:8], gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic finish_load(input int exp_writes, input int base);
    int n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("done_after_write", 32'(cyc - last_wr_cyc), 32'd1);
    check("hold_at_done", 32'(cpu_hold), 32'd1);
    check("error_at_done", 32'(error), 32'd0);
    check("write_count", 32'(wr_count - base), 32'(exp_writes));
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    tick();
    check("hold_fall", 32'(cpu_hold), 32'd0);
    check("done_pulse", 32'(done), 32'd0);
  endtask

  task automatic load_image(input int cnt, input int gap);
    int base = wr_count;
    do_start();
    check("hold_rise", 32'(cpu_hold), 32'd1);
    send_header(16'(cnt), gap);
    for (int i = 0; i < cnt; i++) begin
      sb_q.push_back({32'(i * 4), img[i]});
      send_word(img[i], gap);
    end
    finish_load(cnt, base);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check({tag, "_wr_address"}, wr_address, 32'd0);
    check({tag, "_wr_data"}, wr_data, 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    img[0] = 32'h12320282;
    img[1] = 32'h34508202;
    img[2] = 32'h31108282;
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();
    check("idle_rx_ready", 32'(rx_ready), 32'd0);

    // Streaming load, then the same image with a gap after every byte.
    load_image(3, 0);
    load_image(3, 1);

    // Zero-length header.
    base = wr_count;
    do_start();
    send_header(16'h0000, 0);
    check("zero_error", 32'(error), 32'd1);
    check("zero_hold", 32'(cpu_hold), 32'd0);
    check("zero_rx_ready", 32'(rx_ready), 32'd0);
    repeat (3) tick();
    check("zero_no_write", 32'(wr_count - base), 32'd0);
    do_start();
    check("start_clears_error", 32'(error), 32'd0);

    // One past capacity, then exactly capacity.
    send_header(16'h0401, 0);
    check("over_error", 32'(error), 32'd1);
    check("over_hold", 32'(cpu_hold), 32'd0);
    check("over_no_write", 32'(wr_count - base), 32'd0);
    do_start();
    send_header(16'h0400, 0);
    check("max_error", 32'(error), 32'd0);
    check("max_rx_ready", 32'(rx_ready), 32'd1);
    check("max_hold", 32'(cpu_hold), 32'd1);
    sb_q.push_back({32'd0, img[2]});
    send_word(img[2], 0);
    tick();
    check("max_first_write", 32'(wr_count - base), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Reset in the middle of word 1.
    base = wr_count;
    do_start();
    send_header(16'd2, 0);
    sb_q.push_back({32'd0, img[0]});
    send_word(img[0], 0);
    send_byte(img[1][7:0], 0);
    send_byte(img[1][15:8], 0);
    reset = 1'b1;
    tick();
    check_reset_outputs("midreset");
    reset = 1'b0;
    rx_valid = 1'b1;
    rx_data = 8'hA5;
    repeat (6) tick();
    rx_valid = 1'b0;
    check("midreset_writes", 32'(wr_count - base), 32'd1);
    load_image(3, 0);

    // start during DATA must not restart the load.
    base = wr_count;
    do_start();
    send_header(16'd2, 0);
    sb_q.push_back({32'd0, img[0]});
    send_word(img[0], 0);
    sb_q.push_back({32'd4, img[1]});
    send_byte(img[1][7:0], 0);
    send_byte(img[1][15:8], 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ignored_start_hold", 32'(cpu_hold), 32'd1);
    check("ignored_start_ready", 32'(rx_ready), 32'd1);
    send_byte(img[1][23:16], 0);
    send_byte(img[1][31:24], 0);
    finish_load(2, base);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Boot-time writer for the instruction memory. It accepts a byte stream over a valid/ready handshake and parses a 2-byte word-count header. It then assembles little-endian 32-bit instruction words and issues one write per word at byte addresses 0, 4, 8, … into the instruction memory's write port. While a load is in progress it holds the core via `cpu_hold`, so fetch only begins after the program image is complete.

## Interface
- `Width`, 32, instruction and address width in bits.
- `MaxWords`, 1024, capacity of the instruction memory in words; the largest legal header count.
- `clk`  input  1  single clock; all logic is on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  single-cycle pulse that begins a load; honoured only in IDLE.
- `rx_data`  input  8  incoming byte.
- `rx_valid`  input  1  `rx_data` is valid.
- `rx_ready`  output  1  loader can accept a byte; a byte transfers on `rx_valid && rx_ready`.
- `wr_en`  output  1  instruction-memory write strobe, one cycle per word.
- `wr_address`  output  Width  byte address of the write; always a multiple of 4.
- `wr_data`  output  Width  assembled instruction word.
- `cpu_hold`  output  1  keeps the core in reset while high.
- `done`  output  1  one-cycle pulse when the last word has been written.
- `error`  output  1  sticky flag for an illegal header; cleared by the next accepted `start` or by `reset`.

## Operation
- Stream format:
  - byte0 = count[7:0], byte1 = count[15:8];
  - then 4×count bytes, each word sent LSB first.
- State machine:
  - IDLE: `start` → LEN0, and `cpu_hold` rises.
  - LEN0: on a byte, latch count[7:0] → LEN1.
  - LEN1: on a byte, latch count[15:8] and check the count:
    - count == 0 or count > MaxWords → IDLE, with `error` = 1 and `cpu_hold` = 0;
    - otherwise → DATA.
  - DATA: accept bytes into the assembler; on the 4th byte → WRITE.
  - WRITE: drive `wr_en` for one cycle, then increment the word index:
    - index == count → DONE;
    - otherwise → DATA.
  - DONE: `done` = 1 for one cycle → IDLE, and `cpu_hold` falls.
- `rx_ready` = 1 only in LEN0, LEN1 and DATA. It is 0 in IDLE, WRITE and DONE, so no byte is dropped or double-counted.
- Address and data rules:
  - `wr_address` = index × 4, computed as {index, 2'b00} zero-extended to Width.
  - `wr_data` = {b3, b2, b1, b0}.
- `start` outside IDLE is ignored and has no effect on the state or the counters.
- Bytes arriving while in IDLE are not accepted (`rx_ready` = 0).

## Timing
- Reset values:
  - state IDLE;
  - `rx_ready` 0, `wr_en` 0, `wr_address` 0, `wr_data` 0;
  - `cpu_hold` 0, `done` 0, `error` 0;
  - index 0, byte counter 0.
- `cpu_hold` rises in the cycle after `start` is sampled in IDLE. It falls in the cycle after `done`.
- Write latency: `wr_en` is high in the cycle immediately after the 4th byte of a word transfers. `wr_address` and `wr_data` are valid in that same cycle.
- Word throughput: at most one word per 5 cycles (4 byte transfers plus WRITE).
- Stalls: `rx_valid` low in DATA stalls the load indefinitely; partial-word bytes are retained.
- Reset mid-load: abort immediately with no further write. `cpu_hold` and `done` go to 0. Memory contents already written are left as they are.
- `error` asserts in the cycle after the offending LEN1 byte transfers, and never coincides with `done`.

## Structure
- Package `loader_pkg` holds:
  - the state encoding: IDLE, LEN0, LEN1, DATA, WRITE, DONE;
  - `HEADER_BYTES` = 2 and `BYTES_PER_WORD` = 4.
- One sub-module, `word_assembler`:
  - shifts bytes into a Width-bit register, LSB first;
  - contains a 2-bit byte counter and outputs `word_full`;
  - clears on `reset` or on an explicit `clear` from the FSM.
- The top level contains the FSM, the count and index registers, and the address generation.

## Test plan
- Count 3, then words 0x12320282, 0x34508202, 0x31108282, with `rx_valid` held high:
  - three `wr_en` pulses at addresses 0, 4, 8 carrying exactly those words;
  - `done` one cycle after the third write;
  - `cpu_hold` high from the cycle after `start` through `done`.
- Same image with `rx_valid` toggled 1-0-1 on every byte → identical writes and data; no extra or missing writes.
- Header 0x0000 → `error` = 1, no `wr_en`, `cpu_hold` back to 0. A following `start` clears `error`.
- Header 0x0401 (1025) with MaxWords = 1024 → `error` = 1 and no writes. Header 0x0400 is accepted.
- `reset` pulsed after the 2nd byte of word 1 (count 2, word 0 already written) → all outputs return to reset values and no write to address 4. A new full load then succeeds from address 0.
- `start` pulsed during DATA → ignored; the load completes with the original count.
